// File: rtl/fifo_pkg.sv
// Shared types and flag decoding for the show-ahead FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
  } fifo_flags_t;

  // Flags depend only on the registered occupancy, never on same-cycle requests.
  function automatic fifo_flags_t fifo_decode_flags(input int unsigned count,
                                                    input int unsigned num_slots);
    fifo_flags_t f;
    f.full        = (count == num_slots);
    f.almost_full = (count >= num_slots - 1);
    f.empty       = (count == 0);
    return f;
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; head word is shown combinationally on data_read.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned LOG_NUM_SLOTS = 2,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam int unsigned CNT_W = LOG_NUM_SLOTS + 1;
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE = LOG_NUM_SLOTS'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]    mem_d [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  fifo_flags_t              flags;
  logic                     push, pop;

  always_comb begin
    flags       = fifo_decode_flags(32'(count_q), NUM_SLOTS);
    full        = flags.full;
    almost_full = flags.almost_full;
    empty       = flags.empty;
    data_read   = mem_q[rd_ptr_q];
  end

  always_comb begin
    push     = write & ~full;
    pop      = next_read & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_write;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: stimulus queues expected words, a negedge monitor checks each pop.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_write;
  logic       write;
  logic       full;
  logic       almost_full;
  logic [7:0] data_read;
  logic       next_read;
  logic       empty;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb [$];

  fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_write  (data_write),
    .write       (write),
    .full        (full),
    .almost_full (almost_full),
    .data_read   (data_read),
    .next_read   (next_read),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic e, input logic af, input logic f);
    chk({name, ".empty"}, 32'(empty), 32'(e));
    chk({name, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({name, ".full"}, 32'(full), 32'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A pop happens at the coming edge whenever next_read is high and the FIFO is not empty.
  always @(negedge clk) begin
    if (!rst && next_read && !empty) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word", data_read);
      end else begin
        chk("pop_data", 32'(data_read), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_vals [4];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; write = 1'b0; next_read = 1'b0; data_write = '0;
    tick(); tick();
    rst = 1'b0;
    chk_flags("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.data_read", 32'(data_read), 32'h0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; data_write = fill_vals[i]; sb.push_back(fill_vals[i]);
      tick();
      chk_flags($sformatf("fill%0d", i), 1'b0, i >= 2, i == 3);
      chk($sformatf("fill%0d.head", i), 32'(data_read), 32'h11);
    end
    write = 1'b0;

    // Overflow: dropped word
    write = 1'b1; data_write = 8'h55;
    tick();
    write = 1'b0;
    chk_flags("overflow", 1'b0, 1'b1, 1'b1);

    next_read = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_flags($sformatf("drain%0d", k), k == 4, (4 - k) >= 3, 1'b0);
    end
    next_read = 1'b0;
    chk("drain.sb_left", 32'(sb.size()), 32'd0);

    // Underflow
    next_read = 1'b1;
    tick();
    next_read = 1'b0;
    chk_flags("underflow", 1'b1, 1'b0, 1'b0);
    write = 1'b1; data_write = 8'hA5; sb.push_back(8'hA5);
    tick();
    write = 1'b0;
    chk_flags("after_underflow", 1'b0, 1'b0, 1'b0);
    chk("after_underflow.head", 32'(data_read), 32'hA5);
    next_read = 1'b1;
    tick();
    next_read = 1'b0;
    chk_flags("a5_popped", 1'b1, 1'b0, 1'b0);

    // Streaming across pointer wrap
    write = 1'b1; data_write = 8'hFF; sb.push_back(8'hFF);
    tick();
    for (int i = 0; i < 10; i++) begin
      write = 1'b1; next_read = 1'b1; data_write = 8'(i); sb.push_back(8'(i));
      tick();
      chk_flags($sformatf("stream%0d", i), 1'b0, 1'b0, 1'b0);
    end
    write = 1'b0;
    tick();
    next_read = 1'b0;
    chk_flags("stream_drained", 1'b1, 1'b0, 1'b0);
    chk("stream.sb_left", 32'(sb.size()), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; data_write = 8'(8'h61 + i); sb.push_back(8'(8'h61 + i));
      tick();
    end
    chk_flags("refill", 1'b0, 1'b1, 1'b1);
    write = 1'b1; next_read = 1'b1; data_write = 8'h77;
    tick();
    write = 1'b0; next_read = 1'b0;
    chk_flags("full_both", 1'b0, 1'b1, 1'b0);
    chk("full_both.head", 32'(data_read), 32'h62);

    // Mid-stream reset with 3 words stored; requests ignored in reset cycle
    rst = 1'b1; write = 1'b1; next_read = 1'b1; data_write = 8'h99;
    tick();
    rst = 1'b0; write = 1'b0; next_read = 1'b0;
    sb.delete();
    chk_flags("mid_reset", 1'b1, 1'b0, 1'b0);
    chk("mid_reset.data_read", 32'(data_read), 32'h0);
    tick();
    chk_flags("mid_reset_idle", 1'b1, 1'b0, 1'b0);
    chk("mid_reset_idle.data_read", 32'(data_read), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
# fifo

Small synchronous first-word-fall-through FIFO used as the decoupling buffer inside stream modules such as READ. It sits between a producer that pushes a word whenever `write` is high and a consumer that sees the head word combinationally on `data_read` and pops it with `next_read`. `almost_full` gives latency-bound producers (e.g. BRAM readers) early back-pressure.

## Interface
- `NUM_SLOTS`, default 4: storage depth in words. Must equal 2^`LOG_NUM_SLOTS`.
- `LOG_NUM_SLOTS`, default 2: pointer width in bits.
- `DATA_WIDTH`, default 8: word width in bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `data_write`  in  `DATA_WIDTH`  word to push.
- `write`  in  1  push request, sampled at the clock edge.
- `full`  out  1  count == `NUM_SLOTS`.
- `almost_full`  out  1  count >= `NUM_SLOTS`-1.
- `data_read`  out  `DATA_WIDTH`  head word (show-ahead); valid only while `empty` is 0.
- `next_read`  in  1  pop request; consumes the head word at the clock edge.
- `empty`  out  1  count == 0.

## Operation
- State:
  - storage array of `NUM_SLOTS` x `DATA_WIDTH`
  - write pointer and read pointer, each `LOG_NUM_SLOTS` bits, wrapping modulo `NUM_SLOTS` by natural overflow
  - occupancy count, `LOG_NUM_SLOTS`+1 bits, range 0..`NUM_SLOTS`
- Push accepted iff `write` & ~`full`:
  - store `data_write` at the write pointer
  - increment the write pointer
- Pop accepted iff `next_read` & ~`empty`: increment the read pointer.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged when both or neither occur
- Rejected requests are silently dropped:
  - a write while full loses the word
  - a pop while empty has no effect
- Simultaneous push and pop:
  - not empty, not full: both happen, count unchanged
  - full: pop accepted, push rejected (the acceptance test uses the registered `full`)
  - empty: push accepted, pop ignored
- `data_read` = storage[read pointer], combinational from registered state.
- Flags are decoded combinationally from the registered count only; they never depend on same-cycle `write`/`next_read`.
- Reset (`rst`=1 at an edge, including mid-operation):
  - pointers and count go to 0; storage is cleared to 0
  - outputs after reset: `empty`=1, `full`=0, `almost_full`=0, `data_read`=0
  - `write`/`next_read` are ignored in the reset cycle

## Timing
- Write-to-read latency is 1 cycle: a word pushed at edge N appears on `data_read`, with `empty`=0, after edge N.
- Pop takes effect at the edge; the next word (or `empty`=1) is visible right after that edge.
- Flags update one edge after the causing push or pop. There is no combinational path from `write`/`next_read` to any output.
- Data ordering is strictly FIFO across pointer wrap-around.
- Throughput: one push and one pop per cycle, sustained indefinitely when neither full nor empty.

## Structure
- Single flat module, no sub-modules.
- No shared package needed. Depth and width are parameters only.
- An optional elaboration-time check that `NUM_SLOTS` == 1<<`LOG_NUM_SLOTS` may live locally.

## Test plan
- Reset then idle:
  - `empty`=1, `full`=0, `almost_full`=0, `data_read`=0
  - apply reset mid-stream with 3 words stored: the same values follow on the next cycle
- Fill (defaults, width 8): push 0x11, 0x22, 0x33, 0x44 on consecutive cycles ->
  - `empty` falls after the 1st edge, `almost_full` rises after the 3rd, `full` rises after the 4th
  - `data_read`=0x11 throughout the fill
- Overflow: with the FIFO full, push 0x55 -> dropped; draining yields exactly 0x11, 0x22, 0x33, 0x44, then `empty`=1.
- Underflow: pulse `next_read` while empty -> no state change; a following push of 0xA5 is read back as 0xA5.
- Streaming wrap: push and pop every cycle for 10 cycles with data 0..9 after one pre-load of 0xFF ->
  - output sequence is 0xFF, 0, 1, ..., 8
  - count stays 1 and `empty` stays 0
- Full with simultaneous push and pop: with the FIFO full, assert both ->
  - head pops and the new word is rejected
  - `full`=0 and `almost_full`=1 on the next cycle
